twiddle_fetch_sched: RTL and testbench
======================================

Name: twiddle_fetch_sched

Overview:
- Sequences the twiddle-angle ROM for one radix-2 DIT CORDIC-FFT run of N = 2^LOG2N points.
- Walks every stage and every butterfly, computes the twiddle index and drives the synchronous ROM address.
- Captures the 1-cycle-latency ROM word and hands the angle to the CORDIC rotator over a valid/ready handshake, tagged with stage and butterfly index.

Parameters:
- LOG2N, 8, log2 of FFT size; stages 1..LOG2N, N/2 butterflies per stage.
- ADDR_W, LOG2N-1, ROM address width (N/2 angle entries).
- DATA_W, 32, angle word width (signed, radians scaled by 2^16).
- STG_W, 4, stage tag width (must hold LOG2N).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled in IDLE only.
- o_busy  out  1  high from the cycle after accepted start until DONE exits.
- o_done  out  1  one-cycle pulse after the last angle transfer.
- o_rom_addr  out  ADDR_W  twiddle ROM address.
- i_rom_data  in  DATA_W  ROM output; valid 1 cycle after address.
- o_angle  out  DATA_W  angle presented to the rotator.
- o_angle_valid  out  1  angle/tags valid.
- i_angle_ready  in  1  rotator accepts when valid&ready.
- o_stage  out  STG_W  stage tag, 1..LOG2N.
- o_bfly  out  ADDR_W  butterfly tag, 0..N/2-1.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs and counters 0.
- FSM states: IDLE, FETCH, LATCH, SEND, DONE.
- IDLE: i_start=1 -> FETCH; stage counter=1, butterfly counter=0.
- FETCH: o_rom_addr = k, where k = (b mod 2^(s-1)) << (LOG2N-s) (s = stage, b = butterfly). Stage 1 always gives k=0; stage LOG2N gives k=b. Next: LATCH.
- LATCH: ROM data now valid; register o_angle <= i_rom_data, o_stage <= s, o_bfly <= b; set o_angle_valid. Next: SEND.
- SEND: hold o_angle, o_stage, o_bfly, o_angle_valid stable while i_angle_ready=0.
  - On handshake: clear valid same edge.
  - If b < N/2-1: b++, go to FETCH.
  - Else if s < LOG2N: s++, b=0, go to FETCH.
  - Else go to DONE.
- DONE: o_done=1 for exactly one cycle; o_busy drops; back to IDLE.
- Throughput: one angle per 3 cycles with ready held high. Total transfers: LOG2N*N/2 (1024 at defaults).
- o_rom_addr holds its last value outside FETCH; it is 0 after reset.
- i_start while busy is ignored. i_start in the DONE cycle is ignored.
- Reset mid-run aborts immediately: no o_done, valid drops asynchronously.
- Counters are unsigned; b wraps only through the explicit stage increment, never by overflow.

Optional Feature:
- Macro TWID_INV_EN.
- Defined:
  - Adds input i_inverse (1 bit), latched on accepted start.
  - When latched high, o_angle = two's-complement negation of the ROM word (IFFT rotation). Negation is registered in LATCH, so latency is unchanged.
- Undefined: no port; o_angle = ROM word unchanged.

Decomposition:
- Package fft_ctrl_pkg holds:
  - state enum twid_state_e {IDLE, FETCH, LATCH, SEND, DONE};
  - constant defaults for LOG2N, DATA_W;
  - function twid_index(s, b, LOG2N) returning k.
- One natural sub-module, twid_index_gen: combinational index calculator, reused by the address path and by the bench model.

Test Plan:
- Reset then start, ready tied high -> exactly 1024 valid&ready transfers, then o_done high for 1 cycle, o_busy low after; transfer count per stage 128.
- Stage 1, all b -> o_rom_addr=0 and o_angle=0x00000000 for all 128 transfers.
- Stage 2, b=1 -> addr 64, o_angle=0xFFFE6DE0; b=2 -> addr 0. Stage 8, b=32 -> addr 32, o_angle=0xFFFF36F0.
- Backpressure: hold ready low 5 cycles at stage 3, b=5 -> o_angle, o_stage=3, o_bfly=5 and valid stable for all 5 cycles; exactly one transfer on release.
- Assert i_rst_n low during stage 4 SEND -> outputs 0 asynchronously, no o_done. Re-start -> sequence restarts at stage 1, b=0. Start pulse while busy -> no effect.
- TWID_INV_EN defined, i_inverse=1: stage 8, b=32 -> o_angle=0x0000C910. With i_inverse=0 -> 0xFFFF36F0.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT control slice: FSM encoding, default
// sizes and the radix-2 DIT twiddle index function.
package fft_ctrl_pkg;

  localparam int TWID_LOG2N_DEF  = 8;
  localparam int TWID_DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } twid_state_e;

  // k = (b mod 2^(s-1)) << (LOG2N-s); stage 1 collapses to 0, last stage to b
  function automatic int twid_index(input int s, input int b, input int log2n);
    return (b & ((1 << (s - 1)) - 1)) << (log2n - s);
  endfunction

endpackage

// File: rtl/twid_index_gen.sv
// Combinational twiddle index calculator for a (stage, butterfly) pair.
module twid_index_gen
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N  = TWID_LOG2N_DEF,
  parameter int ADDR_W = LOG2N - 1,
  parameter int STG_W  = 4
) (
  input  logic [STG_W-1:0]  stage,
  input  logic [ADDR_W-1:0] bfly,
  output logic [ADDR_W-1:0] idx
);

  assign idx = ADDR_W'(twid_index(int'(stage), int'(bfly), LOG2N));

endmodule

// File: rtl/twiddle_fetch_sched.sv
// Walks all stages/butterflies of one FFT run, addresses the twiddle ROM and
// hands each angle to the rotator. Optional TWID_INV_EN adds IFFT negation.
module twiddle_fetch_sched
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N  = TWID_LOG2N_DEF,
  parameter int ADDR_W = LOG2N - 1,
  parameter int DATA_W = TWID_DATA_W_DEF,
  parameter int STG_W  = 4
) (
`ifdef TWID_INV_EN
  input  logic              i_inverse,
`endif
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_angle,
  output logic              o_angle_valid,
  input  logic              i_angle_ready,
  output logic [STG_W-1:0]  o_stage,
  output logic [ADDR_W-1:0] o_bfly
);

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_FETCH = 3'(FETCH);
  localparam logic [2:0] ST_LATCH = 3'(LATCH);
  localparam logic [2:0] ST_SEND  = 3'(SEND);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

  localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'((1 << (LOG2N - 1)) - 1);
  localparam logic [STG_W-1:0]  S_LAST = STG_W'(LOG2N);

  logic [2:0]        state_q;
  logic [STG_W-1:0]  stg_q;
  logic [ADDR_W-1:0] bfly_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] idx;
  logic              hs;
`ifdef TWID_INV_EN
  logic              inv_q;
`endif

  twid_index_gen #(
    .LOG2N (LOG2N),
    .ADDR_W(ADDR_W),
    .STG_W (STG_W)
  ) u_idx (
    .stage(stg_q),
    .bfly (bfly_q),
    .idx  (idx)
  );

  assign hs     = o_angle_valid & i_angle_ready;
  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);
  // Address is live in FETCH and held afterwards so the ROM sees a stable input
  assign o_rom_addr = (state_q == ST_FETCH) ? idx : addr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      stg_q         <= '0;
      bfly_q        <= '0;
      addr_q        <= '0;
      o_angle       <= '0;
      o_angle_valid <= 1'b0;
      o_stage       <= '0;
      o_bfly        <= '0;
`ifdef TWID_INV_EN
      inv_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_FETCH;
            stg_q   <= STG_W'(1);
            bfly_q  <= '0;
`ifdef TWID_INV_EN
            inv_q   <= i_inverse;
`endif
          end
        end
        ST_FETCH: begin
          addr_q  <= idx;
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
`ifdef TWID_INV_EN
          o_angle <= inv_q ? -i_rom_data : i_rom_data;
`else
          o_angle <= i_rom_data;
`endif
          o_stage       <= stg_q;
          o_bfly        <= bfly_q;
          o_angle_valid <= 1'b1;
          state_q       <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            o_angle_valid <= 1'b0;
            if (bfly_q != B_LAST) begin
              bfly_q  <= bfly_q + ADDR_W'(1);
              state_q <= ST_FETCH;
            end else if (stg_q != S_LAST) begin
              stg_q   <= stg_q + STG_W'(1);
              bfly_q  <= '0;
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_fetch_sched.sv
// Directed bench for twiddle_fetch_sched with a rounded -2*pi*k/N ROM model.
module tb_twiddle_fetch_sched;

  localparam int LOG2N  = 8;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int STG_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] rom_q = '0;
  logic              busy, done, valid;
  logic [ADDR_W-1:0] addr, bfly;
  logic [DATA_W-1:0] angle;
  logic [STG_W-1:0]  stage;
`ifdef TWID_INV_EN
  logic              inverse = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  twiddle_fetch_sched #(
    .LOG2N (LOG2N),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STG_W (STG_W)
  ) dut (
`ifdef TWID_INV_EN
    .i_inverse    (inverse),
`endif
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_rom_addr   (addr),
    .i_rom_data   (rom_q),
    .o_angle      (angle),
    .o_angle_valid(valid),
    .i_angle_ready(ready),
    .o_stage      (stage),
    .o_bfly       (bfly)
  );

  function automatic logic [31:0] rom_val(input int k);
    real a;
    int  v;
    a = real'(k) * 2.0 * 3.14159265358979 * 65536.0 / 256.0;
    v = $rtoi(a + 0.5);
    return 32'(-v);
  endfunction

  function automatic int exp_k(input int s, input int b);
    return (b % (1 << (s - 1))) << (LOG2N - s);
  endfunction

  // Synchronous ROM, one cycle latency
  always @(posedge clk) rom_q <= rom_val(int'(addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"},  64'(busy),  64'd0);
    chk({pfx, "_done"},  64'(done),  64'd0);
    chk({pfx, "_valid"}, 64'(valid), 64'd0);
    chk({pfx, "_addr"},  64'(addr),  64'd0);
    chk({pfx, "_angle"}, 64'(angle), 64'd0);
    chk({pfx, "_stage"}, 64'(stage), 64'd0);
    chk({pfx, "_bfly"},  64'(bfly),  64'd0);
  endtask

  initial begin
    int s_e, b_e, nxf, cyc, t_first, k;
    int per_stage[9];
    bit seen_done;

    // reset state
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // full run with ready held high
    for (int i = 0; i < 9; i++) per_stage[i] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_e = 1; b_e = 0; nxf = 0; cyc = 0; t_first = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 5000) begin
      start = 1'b0;
      if (valid && ready) begin
        k = exp_k(s_e, b_e);
        chk("xf_stage", 64'(stage), 64'(s_e));
        chk("xf_bfly",  64'(bfly),  64'(b_e));
        chk("xf_addr",  64'(addr),  64'(k));
        chk("xf_angle", 64'(angle), 64'(rom_val(k)));
        if (s_e == 1) chk("s1_angle", 64'(angle), 64'h0);
        if (s_e == 2 && b_e == 1) begin
          chk("s2b1_addr",  64'(addr),  64'd64);
          chk("s2b1_angle", 64'(angle), 64'hFFFE6DE0);
        end
        if (s_e == 2 && b_e == 2) chk("s2b2_addr", 64'(addr), 64'd0);
        if (s_e == 8 && b_e == 32) begin
          chk("s8b32_addr",  64'(addr),  64'd32);
          chk("s8b32_angle", 64'(angle), 64'hFFFF36F0);
        end
        if (nxf == 0) t_first = cyc;
        if (nxf == 1) chk("thruput", 64'(cyc - t_first), 64'd3);
        per_stage[s_e]++;
        nxf++;
        if (b_e < 127) b_e++;
        else begin b_e = 0; s_e++; end
        if (nxf == 10) start = 1'b1;  // ignored while busy
      end
      if (done) seen_done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 64'(seen_done), 64'd1);
    chk("xf_total",  64'(nxf),       64'd1024);
    for (int s = 1; s <= 8; s++) chk("xf_per_stage", 64'(per_stage[s]), 64'd128);
    start = 1'b1;  // start during DONE is ignored
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    chk("idle_stays", 64'(busy), 64'd0);

    // backpressure at stage 3, b=5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(valid && stage == 4'd3 && bfly == 7'd5) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_reach", 64'(valid && stage == 4'd3 && bfly == 7'd5), 64'd1);
    ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("bp_valid", 64'(valid), 64'd1);
      chk("bp_stage", 64'(stage), 64'd3);
      chk("bp_bfly",  64'(bfly),  64'd5);
      chk("bp_angle", 64'(angle), 64'hFFFF36F0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(valid), 64'd0);
    cyc = 0;
    while (!valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_next_stage", 64'(stage), 64'd3);
    chk("bp_next_bfly",  64'(bfly),  64'd6);
    chk("bp_next_addr",  64'(addr),  64'd64);

    // reset during a stage-4 SEND
    cyc = 0;
    while (!(valid && stage == 4'd4) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach", 64'(valid && stage == 4'd4), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("restart_stage", 64'(stage), 64'd1);
    chk("restart_bfly",  64'(bfly),  64'd0);
    chk("restart_valid", 64'(valid), 64'd1);

`ifdef TWID_INV_EN
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      inverse = (pass == 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      inverse = 1'b0;
      cyc = 0;
      while (!(valid && stage == 4'd8 && bfly == 7'd32) && cyc < 5000) begin
        @(negedge clk);
        cyc++;
      end
      if (pass == 0) chk("inv_angle", 64'(angle), 64'h0000C910);
      else           chk("fwd_angle", 64'(angle), 64'hFFFF36F0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
